fmul_pipe: RTL and testbench

FMUL_PIPE -- requirements
Module: fmul_pipe

---
 rtl/fmul_pkg.sv | 37 +++
 rtl/fmul_round.sv | 70 +++++++
 rtl/fmul_pipe.sv | 150 +++++++++++++++
 tb/tb_fmul_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// fmul_pkg: shared encodings, flag indices and bias helper
// for the pipelined floating-point multiplier.
package fmul_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    localparam int FL_NV = 3;
    localparam int FL_OF = 2;
    localparam int FL_UF = 1;
    localparam int FL_NX = 0;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // exp==0 is always zero: subnormals are flushed
    function automatic cls_t classify(
        input logic exp_zero,
        input logic exp_ones,
        input logic man_zero
    );
        cls_t c;
        unique case (1'b1)
            exp_zero:              c = CLS_ZERO;
            exp_ones && man_zero:  c = CLS_INF;
            exp_ones && !man_zero: c = CLS_NAN;
            default:               c = CLS_NORM;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fmul_round.sv
// fmul_round: combinational round, pack and flag logic
// for the final multiplier stage.
module fmul_round
    import fmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                    sign,
    input  cls_t                    kind,
    input  logic signed [EXP_W+1:0] expo,
    input  logic [MAN_W-1:0]        man,
    input  logic                    guard,
    input  logic                    sticky,
    input  logic                    rm,
    output logic [EXP_W+MAN_W:0]    y,
    output logic [3:0]              flags
);

    localparam logic signed [EXP_W+1:0] EMAX =
        {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EXP_W+1:0] EZERO = '0;

    logic                    inc;
    logic                    inexact;
    logic [MAN_W:0]          sum;
    logic [MAN_W-1:0]        man_r;
    logic signed [EXP_W+1:0] exp_r;

    // a carry out of the mantissa leaves man_r all zero
    always_comb begin
        inc     = rm & guard & (sticky | man[0]);
        inexact = guard | sticky;
        sum     = {1'b0, man} + {{MAN_W{1'b0}}, inc};
        man_r   = sum[MAN_W-1:0];
        exp_r   = expo + $signed({{(EXP_W+1){1'b0}}, sum[MAN_W]});
    end

    always_comb begin
        y     = '0;
        flags = '0;
        unique case (kind)
            CLS_NAN: begin
                y = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                flags[FL_NV] = 1'b1;
            end
            CLS_INF: begin
                y = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
            CLS_ZERO: begin
                y = {sign, {(EXP_W+MAN_W){1'b0}}};
            end
            default: begin
                flags[FL_NX] = inexact;
                if (exp_r >= EMAX) begin
                    y = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags[FL_OF] = 1'b1;
                    flags[FL_NX] = 1'b1;
                end else if (exp_r <= EZERO) begin
                    y = {sign, {(EXP_W+MAN_W){1'b0}}};
                    flags[FL_UF] = 1'b1;
                    flags[FL_NX] = 1'b1;
                end else begin
                    y = {sign, exp_r[EXP_W-1:0], man_r};
                end
            end
        endcase
    end

endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: 3-stage floating-point multiplier with
// valid/ready flow control and a sideband tag.
module fmul_pipe
    import fmul_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   x1,
    input  logic [EXP_W+MAN_W:0]   x2,
    input  logic                   rm,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   y,
    output logic [3:0]             flags,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * (MAN_W + 1);
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] BIAS = EW'(bias(EXP_W));

    typedef struct packed {
        logic             valid;
        logic             sign;
        cls_t             kind;
        logic [EXP_W-1:0] e1;
        logic [EXP_W-1:0] e2;
        logic [PW-1:0]    prod;
        logic             rm;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             sign;
        cls_t             kind;
        logic [EW-1:0]    expo;
        logic [MAN_W-1:0] man;
        logic             guard;
        logic             sticky;
        logic             rm;
        logic [TAG_W-1:0] tag;
    } s2_t;

    logic             advance;
    s1_t              s1_d, s1_q;
    s2_t              s2_d, s2_q;
    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] m1, m2;
    cls_t             c1, c2;
    logic             any_nan, any_inf, any_zero;
    logic             msb;
    logic [PW-2:0]    norm;
    logic [W-1:0]     y_d;
    logic [3:0]       flags_d;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance || !rstn;

    assign e1 = x1[MAN_W +: EXP_W];
    assign e2 = x2[MAN_W +: EXP_W];
    assign m1 = x1[MAN_W-1:0];
    assign m2 = x2[MAN_W-1:0];
    assign c1 = classify(e1 == '0, &e1, m1 == '0);
    assign c2 = classify(e2 == '0, &e2, m2 == '0);

    assign any_nan  = (c1 == CLS_NAN)  || (c2 == CLS_NAN);
    assign any_inf  = (c1 == CLS_INF)  || (c2 == CLS_INF);
    assign any_zero = (c1 == CLS_ZERO) || (c2 == CLS_ZERO);

    always_comb begin
        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.sign  = x1[W-1] ^ x2[W-1];
        s1_d.e1    = e1;
        s1_d.e2    = e2;
        s1_d.prod  = PW'({1'b1, m1}) * PW'({1'b1, m2});
        s1_d.rm    = rm;
        s1_d.tag   = in_tag;
        if (any_nan || (any_inf && any_zero))
            s1_d.kind = CLS_NAN;
        else if (any_inf)
            s1_d.kind = CLS_INF;
        else if (any_zero)
            s1_d.kind = CLS_ZERO;
        else
            s1_d.kind = CLS_NORM;
    end

    // norm holds the bits below the leading one
    assign msb  = s1_q.prod[PW-1];
    assign norm = msb ? s1_q.prod[PW-2:0]
                      : {s1_q.prod[PW-3:0], 1'b0};

    always_comb begin
        s2_d        = '0;
        s2_d.valid  = s1_q.valid;
        s2_d.sign   = s1_q.sign;
        s2_d.kind   = s1_q.kind;
        s2_d.expo   = EW'(s1_q.e1) + EW'(s1_q.e2)
                    - BIAS + EW'(msb);
        s2_d.man    = norm[PW-2 -: MAN_W];
        s2_d.guard  = norm[PW-2-MAN_W];
        s2_d.sticky = |norm[PW-3-MAN_W:0];
        s2_d.rm     = s1_q.rm;
        s2_d.tag    = s1_q.tag;
    end

    fmul_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign   (s2_q.sign),
        .kind   (s2_q.kind),
        .expo   (s2_q.expo),
        .man    (s2_q.man),
        .guard  (s2_q.guard),
        .sticky (s2_q.sticky),
        .rm     (s2_q.rm),
        .y      (y_d),
        .flags  (flags_d)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_q      <= '0;
            s2_q      <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            flags     <= '0;
            out_tag   <= '0;
        end else if (advance) begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            out_valid <= s2_q.valid;
            y         <= y_d;
            flags     <= flags_d;
            out_tag   <= s2_q.tag;
        end
    end

endmodule

// File: tb/tb_fmul_pipe.sv
// tb_fmul_pipe: directed vectors with a scoreboard queue
// and a decoupled output monitor.
module tb_fmul_pipe;

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1, x2;
    logic        rm;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic [3:0]  flags;
    logic [3:0]  out_tag;

    typedef struct {
        logic [31:0] y;
        logic [3:0]  f;
        logic [3:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          lat_chk;
    logic [3:0]  tag_ctr = 4'h0;
    logic [31:0] y_hold;
    logic [3:0]  tag_hold;

    fmul_pipe #(
        .EXP_W (8),
        .MAN_W (23),
        .TAG_W (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .rm        (rm),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags),
        .out_tag   (out_tag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endfunction

    // monitor: pops one expectation per accepted result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rstn && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", {28'h0, out_tag}, 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    chk("y", y, e.y);
                    chk("flags", {28'h0, flags}, {28'h0, e.f});
                    chk("tag", {28'h0, out_tag}, {28'h0, e.tag});
                    if (e.lat)
                        chk("latency", cyc - e.acc, 3);
                end
            end
        end
    end

    task automatic send(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic        r,
                        input logic [31:0] ey,
                        input logic [3:0]  ef);
        int   n;
        exp_t e;
        x1 = a;
        x2 = b;
        rm = r;
        in_tag = tag_ctr;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_ready", {31'h0, in_ready}, 32'h1);
        if (in_ready) begin
            e.y   = ey;
            e.f   = ef;
            e.tag = tag_ctr;
            e.acc = cyc + 1;
            e.lat = lat_chk;
            sbq.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        tag_ctr++;
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        in_valid = 1'b0;
        x1 = '0;
        x2 = '0;
        rm = 1'b0;
        in_tag = '0;
        out_ready = 1'b1;
        lat_chk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_y", y, 32'h0);
        chk("rst_flags", {28'h0, flags}, 32'h0);
        chk("rst_tag", {28'h0, out_tag}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        rstn = 1'b1;

        // directed vectors, flags = {nv, of, uf, nx}
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000);
        send(32'h3F800001, 32'h3FC00000, 1'b1, 32'h3FC00002, 4'b0001);
        send(32'h3F800001, 32'h3FC00000, 1'b0, 32'h3FC00001, 4'b0001);
        send(32'h7F000000, 32'h40000000, 1'b1, 32'h7F800000, 4'b0101);
        send(32'h7F800000, 32'h00000000, 1'b1, 32'h7FC00000, 4'b1000);
        send(32'h00800000, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
        send(32'hC0000000, 32'h40400000, 1'b1, 32'hC0C00000, 4'b0000);
        send(32'hFF800000, 32'h40000000, 1'b1, 32'hFF800000, 4'b0000);
        send(32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00000, 4'b1000);
        send(32'hFF800000, 32'h80000000, 1'b1, 32'h7FC00000, 4'b1000);
        send(32'h80000000, 32'h3F800000, 1'b1, 32'h80000000, 4'b0000);
        send(32'h00000001, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        send(32'h3F800003, 32'h3FC00000, 1'b1, 32'h3FC00004, 4'b0001);
        send(32'h3FA3D70A, 32'h3FC80000, 1'b1, 32'h40000000, 4'b0001);
        send(32'h3FA3D70A, 32'h3FC80000, 1'b0, 32'h3FFFFFFF, 4'b0001);
        repeat (5) @(posedge clk);
        #1;

        // back-to-back with a 5-cycle consumer stall
        lat_chk = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000);
        send(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 4'b0000);
        send(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h40100000, 4'b0000);
        send(32'hBF800000, 32'h3F000000, 1'b1, 32'hBF000000, 4'b0000);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_start_valid", {31'h0, out_valid}, 32'h1);
        out_ready = 1'b0;
        y_hold = y;
        tag_hold = out_tag;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
            chk("stall_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_y", y, y_hold);
            chk("stall_tag", {28'h0, out_tag}, {28'h0, tag_hold});
        end
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // reset with three operations in flight
        send(32'h40000000, 32'h40000000, 1'b1, 32'h40800000, 4'b0000);
        send(32'h40400000, 32'h40400000, 1'b1, 32'h41100000, 4'b0000);
        out_ready = 1'b0;
        send(32'h3FC00000, 32'h40000000, 1'b1, 32'h40400000, 4'b0000);
        chk("pre_rst_in_ready", {31'h0, in_ready}, 32'h0);
        rstn = 1'b0;
        #1;
        chk("in_rst_in_ready", {31'h0, in_ready}, 32'h1);
        sbq.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin
            chk("post_rst_valid", {31'h0, out_valid}, 32'h0);
            chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
            @(posedge clk);
            #1;
        end
        lat_chk = 1'b1;
        send(32'h40000000, 32'h40000000, 1'b1, 32'h40800000, 4'b0000);

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain_empty", sbq.size(), 0);
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
